// File: rtl/cnn_pkg.sv
// Shared CNN constants, activation types and the pooling combine function.
// SUBSAMPLE_AVG_EN selects sum/average pooling; the default build is max pooling.
package cnn_pkg;

    localparam int IMG_SIZE  = 32;
    localparam int K         = 5;
    localparam int CONV_SIZE = IMG_SIZE - K + 1;
    localparam int POOL_SIZE = CONV_SIZE / 2;
    localparam int ACT_WIDTH = 32;

`ifdef SUBSAMPLE_AVG_EN
    localparam int ACC_GROWTH = 2;
`else
    localparam int ACC_GROWTH = 0;
`endif

    typedef logic signed [ACT_WIDTH-1:0] act_t;
    typedef logic signed [63:0]          wide_t;

    typedef enum logic [1:0] {
        SKIP,
        EVEN_ROW,
        ODD_ROW
    } pool_state_e;

    // Operands arrive sign-extended to 64 bits so one function serves any width.
    function automatic wide_t pool_combine(input wide_t acc, input wide_t x);
`ifdef SUBSAMPLE_AVG_EN
        return acc + x;
`else
        return (x > acc) ? x : acc;
`endif
    endfunction

endpackage

// File: rtl/pool_unit.sv
// Per-map pooling datapath: seed, combine and final output for one activation lane.
// SUBSAMPLE_AVG_EN switches combine to a growing sum and output to sum >>> 2.
module pool_unit #(
    parameter int BIT_WIDTH = 32,
    parameter int ACC_WIDTH = BIT_WIDTH + cnn_pkg::ACC_GROWTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [BIT_WIDTH-1:0] x,
    output logic signed [ACC_WIDTH-1:0] seed,
    output logic signed [ACC_WIDTH-1:0] comb,
    output logic signed [BIT_WIDTH-1:0] pooled
);
    import cnn_pkg::*;

    always_comb begin
        seed = ACC_WIDTH'(x);
        comb = ACC_WIDTH'(pool_combine(wide_t'(acc), wide_t'(x)));
`ifdef SUBSAMPLE_AVG_EN
        pooled = BIT_WIDTH'(comb >>> 2);
`else
        pooled = BIT_WIDTH'(comb);
`endif
    end

endmodule

// File: rtl/subsampling_layer_1.sv
// 2x2 stride-2 pooling of the first conv stage's raster-order MAPS-wide output stream.
// Define SUBSAMPLE_AVG_EN for average pooling; max pooling otherwise.
module subsampling_layer_1 #(
    parameter int IMG_SIZE  = 32,
    parameter int K         = 5,
    parameter int BIT_WIDTH = 32,
    parameter int MAPS      = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clear,
    input  logic [BIT_WIDTH*MAPS-1:0] in,
    output logic [BIT_WIDTH*MAPS-1:0] out,
    output logic                      out_valid,
    output logic                      frame_done
);
    import cnn_pkg::*;

    localparam int CONV = IMG_SIZE - K + 1;
    localparam int POOL = CONV / 2;
    localparam int CW   = $clog2(IMG_SIZE);
    localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int AW   = BIT_WIDTH + ACC_GROWTH;
    localparam logic [CW-1:0] KM1  = CW'(K - 1);
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    logic [CW-1:0]             col, row, r, c;
    logic [PW-1:0]             pidx;
    pool_state_e               state;
    logic [AW*MAPS-1:0]        hold, acc, seed, comb;
    logic [BIT_WIDTH*MAPS-1:0] pooled;
    logic [AW*MAPS-1:0]        rowbuf [POOL];

    // State is purely a decode of the raster counters.
    always_comb begin
        r    = row - KM1;
        c    = col - KM1;
        pidx = PW'(c >> 1);
        if (row < KM1 || col < KM1)
            state = SKIP;
        else if (r[0])
            state = ODD_ROW;
        else
            state = EVEN_ROW;
        acc = (state == ODD_ROW && !c[0]) ? rowbuf[pidx] : hold;
    end

    for (genvar m = 0; m < MAPS; m++) begin : g_map
        pool_unit #(
            .BIT_WIDTH(BIT_WIDTH),
            .ACC_WIDTH(AW)
        ) u_pool (
            .acc   (acc[AW*m +: AW]),
            .x     (in[BIT_WIDTH*m +: BIT_WIDTH]),
            .seed  (seed[AW*m +: AW]),
            .comb  (comb[AW*m +: AW]),
            .pooled(pooled[BIT_WIDTH*m +: BIT_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (en) begin
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                case (state)
                    EVEN_ROW: if (!c[0]) hold <= seed;
                    ODD_ROW: begin
                        if (!c[0]) begin
                            hold <= comb;
                        end else begin
                            out        <= pooled;
                            out_valid  <= 1'b1;
                            frame_done <= (row == LAST) && (col == LAST);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Row buffer is always written before it is read within a frame, so it needs no reset.
    always_ff @(posedge clk) begin
        if (en && !clear && state == EVEN_ROW && c[0])
            rowbuf[pidx] <= comb;
    end

endmodule

// File: doc/subsampling_layer_1.md
# subsampling_layer_1

Receiving end of the first convolutional stage's output stream. Accepts one MAPS-wide vector of activations per enabled cycle, aligned with the raster-order input pixel stream that feeds the convolution. Discards the samples taken before the line buffers are filled, applies 2×2 stride-2 max pooling per map, and emits a 14×14 pooled stream per 32×32 frame for the next layer.

## Interface
- IMG_SIZE, 32: input image edge; conv output edge is IMG_SIZE-K+1.
- K, 5: convolution kernel edge.
- BIT_WIDTH, 32: signed width of one activation.
- MAPS, 6: number of feature maps packed in one vector.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  one conv sample present on `in` this cycle; advances the raster position.
- clear  input  1  synchronous frame restart; has priority over en.
- in  input  BIT_WIDTH*MAPS  conv activations; map m at [BIT_WIDTH*(m+1)-1 : BIT_WIDTH*m].
- out  output  BIT_WIDTH*MAPS  pooled activations, same packing.
- out_valid  output  1  `out` holds a new pooled vector; one-cycle pulse.
- frame_done  output  1  pulses together with the last (196th) out_valid of a frame.

## Operation
- Raster counters col (0..IMG_SIZE-1) and row (0..IMG_SIZE-1) advance only on en; col wraps to 0 and increments row; row wraps to 0 after the last pixel (frame boundary, back-to-back frames need no gap).
- Sample is a valid conv point when row>=K-1 and col>=K-1; conv coordinates r=row-(K-1), c=col-(K-1), range 0..27. All other enabled samples are dropped without side effects.
- State machine: SKIP (row<K-1 or col<K-1), EVEN_ROW (r even), ODD_ROW (r odd). State is a decode of the counters, not separate storage.
- EVEN_ROW, c even: hold <= in. c odd: rowbuf[c/2] <= max(hold, in).
- ODD_ROW, c even: hold <= max(rowbuf[c/2], in). c odd: out <= max(hold, in), out_valid pulses.
- Row buffer: (IMG_SIZE-K+1)/2 = 14 entries × BIT_WIDTH*MAPS. Written only in EVEN_ROW, read only in ODD_ROW; no read-before-write within a frame, so not reset.
- Comparisons are signed, per map, independent; output width equals input width (no growth for max).
- clear or rst_n low mid-frame: counters to 0, hold discarded, pending pooling window abandoned, no out_valid for it.
- en low: everything holds; out keeps its last value.

## Timing
- Reset values: out=0, out_valid=0, frame_done=0, col=0, row=0, hold=0.
- Latency: out/out_valid register one cycle after the en cycle carrying the bottom-right sample of a 2×2 window.
- out_valid never asserts on consecutive cycles; minimum spacing two enabled samples.
- frame_done asserts with out_valid for r=27, c=27 (row=31, col=31).
- No backpressure: downstream must accept every out_valid pulse.
- clear and en in the same cycle: clear wins, sample discarded, counters 0 next cycle.

## Configuration
- SUBSAMPLE_AVG_EN defined: average pooling. hold and rowbuf store BIT_WIDTH+2-bit signed partial sums; output = (sum of four) >>> 2 (arithmetic, truncates toward -inf), resized to BIT_WIDTH.
- Undefined: max pooling as above; storage BIT_WIDTH per map.

## Structure
- Shared package cnn_pkg: IMG_SIZE, K, CONV_SIZE, POOL_SIZE constants, signed activation typedef, pool-combine function.
- One sub-module pool_unit: per-map combine (max or sum per SUBSAMPLE_AVG_EN), generated MAPS times; counters, row buffer, control in the top.

## Test plan
- Frame of all-zero pixels except conv point (r=0,c=0) map 0 = 100 -> first out_valid at row=5,col=5 enable +1 cycle, map0=100, others 0.
- Ramp: conv value = r*28+c on every map -> pooled (i,j) = (2i+1)*28+2j+1; 196 pulses, frame_done with last, value 783.
- Negative values: window {-5,-3,-9,-7} -> max -3; with SUBSAMPLE_AVG_EN -> -6.
- en toggled randomly 50% during ramp frame -> identical output sequence to continuous en.
- clear asserted at row=20,col=10 then fresh frame -> no stale output; exactly 196 pulses for new frame.
- rst_n pulsed low mid-frame -> all outputs 0 immediately (asynchronously); next frame correct.
